msrv32_dmem_responder: RTL and testbench

- AHB-Lite style data-memory responder: the slave end of the core's data-memory port.
- Accepts address/control from the core's store/load path and holds a word-organised SRAM model with byte-lane writes.
- Returns read data, inserts a programmable number of wait states via hready, and issues a two-cycle ERROR response for out-of-range addresses.
- Sits beside the core top in SoC/testbench integration, wired to the dmaddr/dmdata/dmwr_req/dmwr_mask/htrans outputs and the data_in/data_hready/hresp inputs.

---
 rtl/msrv32_dmem_responder_if.sv | 21 ++
 rtl/msrv32_dmem_responder.sv | 173 +++++++++++++++++
 tb/tb_msrv32_dmem_responder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/msrv32_dmem_responder_if.sv
// rtl/msrv32_dmem_responder_if.sv - data-memory bus between the core (master) and the responder (slave)
interface msrv32_dmem_responder_if;
  logic [31:0] dmaddr_in;
  logic [31:0] dmdata_in;
  logic        dmwr_req_in;
  logic [3:0]  dmwr_mask_in;
  logic [1:0]  htrans_in;
  logic [31:0] data_out;
  logic        data_hready_out;
  logic        hresp_out;

  modport master (
    output dmaddr_in, dmdata_in, dmwr_req_in, dmwr_mask_in, htrans_in,
    input  data_out, data_hready_out, hresp_out
  );

  modport slave (
    input  dmaddr_in, dmdata_in, dmwr_req_in, dmwr_mask_in, htrans_in,
    output data_out, data_hready_out, hresp_out
  );
endinterface

// File: rtl/msrv32_dmem_responder.sv
// rtl/msrv32_dmem_responder.sv - AHB-Lite style data-memory slave with wait states and ERROR responses
// Optional transfer counters are built when MSRV32_DMEM_STATS_EN is defined.
module msrv32_dmem_responder #(
  parameter int          MEM_DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0001_0000,
  parameter int          WAIT_STATES     = 1
) (
  input  logic                   ms_riscv32_mp_clk_in,
  input  logic                   ms_riscv32_mp_rst_in,
  msrv32_dmem_responder_if.slave bus
`ifdef MSRV32_DMEM_STATS_EN
  ,
  output logic [31:0]            rd_count_out,
  output logic [31:0]            wr_count_out,
  output logic [7:0]             err_count_out
`endif
);

  localparam int         AW       = $clog2(MEM_DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          hready_q, hready_d;
  logic          hresp_q, hresp_d;
  logic [31:0]   rdata_q;

  logic          pend_q;
  logic          pend_wr_q;
  logic [AW-1:0] pend_idx_q;
  logic [3:0]    pend_mask_q;

  logic [31:0]   mem [MEM_DEPTH_WORDS];

  logic          accept;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          complete;
  logic          commit_wr;
  logic [31:0]   rd_word;

  wire unused_bus_bits = ^{bus.htrans_in[0], bus.dmaddr_in[1:0]};

  // BASE_ADDR is aligned to the array size, so the range check is an upper-bit compare.
  assign in_range  = (bus.dmaddr_in[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign idx       = bus.dmaddr_in[AW+1:2];
  assign accept    = hready_q && bus.htrans_in[1];
  assign complete  = (state_q == S_IDLE) && pend_q;
  assign commit_wr = complete && pend_wr_q;

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          if (!in_range) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the block straight from flops.
  always_comb begin
    hready_d = (state_d == S_IDLE) || (state_d == S_ERR2);
    hresp_d  = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  always_comb begin
    rd_word = mem[idx];
    if (commit_wr && (pend_idx_q == idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (pend_mask_q[b]) begin
          rd_word[8*b +: 8] = bus.dmdata_in[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      pend_q      <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_idx_q  <= '0;
      pend_mask_q <= 4'd0;
      rdata_q     <= 32'd0;
    end else begin
      if (accept && in_range) begin
        pend_q      <= 1'b1;
        pend_wr_q   <= bus.dmwr_req_in;
        pend_idx_q  <= idx;
        pend_mask_q <= bus.dmwr_mask_in;
        if (!bus.dmwr_req_in) begin
          rdata_q <= rd_word;
        end
      end else if (complete) begin
        pend_q <= 1'b0;
      end
    end
  end

  // The array has no reset; an abandoned transfer never reaches commit_wr because pend_q is cleared.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (commit_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (pend_mask_q[b]) begin
          mem[pend_idx_q][8*b +: 8] <= bus.dmdata_in[8*b +: 8];
        end
      end
    end
  end

`ifdef MSRV32_DMEM_STATS_EN
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      rd_count_out  <= 32'd0;
      wr_count_out  <= 32'd0;
      err_count_out <= 8'd0;
    end else begin
      if (complete && !pend_wr_q) begin
        rd_count_out <= rd_count_out + 32'd1;
      end
      if (commit_wr) begin
        wr_count_out <= wr_count_out + 32'd1;
      end
      if ((state_q == S_ERR2) && (err_count_out != 8'hFF)) begin
        err_count_out <= err_count_out + 8'd1;
      end
    end
  end
`endif

  assign bus.data_out        = rdata_q;
  assign bus.data_hready_out = hready_q;
  assign bus.hresp_out       = hresp_q;

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// tb/tb_msrv32_dmem_responder.sv - directed bench for msrv32_dmem_responder (one and zero wait states)
module tb_msrv32_dmem_responder;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  msrv32_dmem_responder_if bus1 ();
  msrv32_dmem_responder_if bus0 ();

`ifdef MSRV32_DMEM_STATS_EN
  logic [31:0] rd_cnt1, wr_cnt1, rd_cnt0, wr_cnt0;
  logic [7:0]  err_cnt1, err_cnt0;
`endif

  msrv32_dmem_responder #(.MEM_DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_STATES(1)) dut1 (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .bus                  (bus1)
`ifdef MSRV32_DMEM_STATS_EN
    ,
    .rd_count_out         (rd_cnt1),
    .wr_count_out         (wr_cnt1),
    .err_count_out        (err_cnt1)
`endif
  );

  msrv32_dmem_responder #(.MEM_DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .bus                  (bus0)
`ifdef MSRV32_DMEM_STATS_EN
    ,
    .rd_count_out         (rd_cnt0),
    .wr_count_out         (wr_cnt0),
    .err_count_out        (err_cnt0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit d, input logic [1:0] tr, input logic wr,
                       input logic [31:0] addr, input logic [3:0] mask);
    if (d) begin
      bus1.htrans_in = tr; bus1.dmwr_req_in = wr; bus1.dmaddr_in = addr; bus1.dmwr_mask_in = mask;
    end else begin
      bus0.htrans_in = tr; bus0.dmwr_req_in = wr; bus0.dmaddr_in = addr; bus0.dmwr_mask_in = mask;
    end
  endtask

  task automatic set_wdata(input bit d, input logic [31:0] wdata);
    if (d) bus1.dmdata_in = wdata;
    else   bus0.dmdata_in = wdata;
  endtask

  function automatic logic rdy(input bit d);
    return d ? bus1.data_hready_out : bus0.data_hready_out;
  endfunction

  function automatic logic rsp(input bit d);
    return d ? bus1.hresp_out : bus0.hresp_out;
  endfunction

  function automatic logic [31:0] rdat(input bit d);
    return d ? bus1.data_out : bus0.data_out;
  endfunction

  // One transfer: address phase, then data phase until hready; exits in the completion cycle.
  task automatic access(input bit d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        output logic [31:0] rdata, output int lows, output logic resp_seen);
    drive(d, 2'b10, wr, addr, mask);
    step();
    drive(d, 2'b00, 1'b0, 32'h0, 4'h0);
    set_wdata(d, wdata);
    lows = 0;
    resp_seen = 1'b0;
    for (int i = 0; i < 20 && !rdy(d); i++) begin
      lows++;
      resp_seen = resp_seen | rsp(d);
      step();
    end
    resp_seen = resp_seen | rsp(d);
    rdata = rdat(d);
  endtask

  logic [31:0] rd;
  int          lows;
  logic        resp;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    drive(1'b1, 2'b00, 1'b0, 32'h0, 4'h0);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 4'h0);
    set_wdata(1'b1, 32'h0);
    set_wdata(1'b0, 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    check("rst_hready", 32'(rdy(1'b1)), 32'd1);
    check("rst_hresp", 32'(rsp(1'b1)), 32'd0);
    check("rst_data", rdat(1'b1), 32'h0);

    access(1'b1, 1'b1, BASE + 32'h8, 32'hDEADBEEF, 4'hF, rd, lows, resp);
    check("wr8_lows", 32'(lows), 32'd1);
    check("wr8_resp", 32'(resp), 32'd0);
    access(1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0, rd, lows, resp);
    check("rd8_lows", 32'(lows), 32'd1);
    check("rd8_resp", 32'(resp), 32'd0);
    check("rd8_data", rd, 32'hDEADBEEF);

    access(1'b1, 1'b1, BASE + 32'h4, 32'h11223344, 4'hF, rd, lows, resp);
    access(1'b1, 1'b1, BASE + 32'h4, 32'hAABBCCDD, 4'h2, rd, lows, resp);
    access(1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'h0, rd, lows, resp);
    check("rd4_mask0010", rd, 32'h1122CC44);
    access(1'b1, 1'b1, BASE + 32'h4, 32'hFFFFFFFF, 4'h0, rd, lows, resp);
    check("wr4_mask0000_resp", 32'(resp), 32'd0);
    access(1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'h0, rd, lows, resp);
    check("rd4_after_mask0000", rd, 32'h1122CC44);

    access(1'b1, 1'b1, BASE + 32'hFFC, 32'h0BADF00D, 4'hF, rd, lows, resp);
    access(1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'h0, rd, lows, resp);

    drive(1'b1, 2'b10, 1'b0, BASE + 32'h1000, 4'h0);
    step();
    drive(1'b1, 2'b00, 1'b0, 32'h0, 4'h0);
    check("err1_hready", 32'(rdy(1'b1)), 32'd0);
    check("err1_hresp", 32'(rsp(1'b1)), 32'd1);
    step();
    check("err2_hready", 32'(rdy(1'b1)), 32'd1);
    check("err2_hresp", 32'(rsp(1'b1)), 32'd1);
    check("err2_data_held", rdat(1'b1), 32'h1122CC44);
    step();
    check("post_err_hready", 32'(rdy(1'b1)), 32'd1);
    check("post_err_hresp", 32'(rsp(1'b1)), 32'd0);

    access(1'b1, 1'b1, BASE - 32'h4, 32'h76543210, 4'hF, rd, lows, resp);
    check("wr_below_resp", 32'(resp), 32'd1);
    check("wr_below_lows", 32'(lows), 32'd1);
    access(1'b1, 1'b0, BASE + 32'hFFC, 32'h0, 4'h0, rd, lows, resp);
    check("rd_top_unchanged", rd, 32'h0BADF00D);
    check("rd_top_resp", 32'(resp), 32'd0);
    access(1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0, rd, lows, resp);
    check("rd8_unchanged", rd, 32'hDEADBEEF);

    access(1'b1, 1'b1, BASE + 32'h20, 32'hCAFEF00D, 4'hF, rd, lows, resp);
    drive(1'b1, 2'b10, 1'b1, BASE + 32'h20, 4'hF);
    step();
    drive(1'b1, 2'b00, 1'b0, 32'h0, 4'h0);
    set_wdata(1'b1, 32'h12345678);
    check("rst_wait_hready", 32'(rdy(1'b1)), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_hready", 32'(rdy(1'b1)), 32'd1);
    check("midrst_hresp", 32'(rsp(1'b1)), 32'd0);
    check("midrst_data", rdat(1'b1), 32'h0);
    step();
    rst_n = 1'b1;
    access(1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'h0, rd, lows, resp);
    check("rd20_after_rst", rd, 32'hCAFEF00D);

    drive(1'b0, 2'b10, 1'b1, BASE + 32'h10, 4'hF);
    step();
    check("ws0_wr_hready", 32'(rdy(1'b0)), 32'd1);
    set_wdata(1'b0, 32'h55AA55AA);
    drive(1'b0, 2'b10, 1'b0, BASE + 32'h10, 4'h0);
    step();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 4'h0);
    check("ws0_rd_hready", 32'(rdy(1'b0)), 32'd1);
    check("ws0_fwd_data", rdat(1'b0), 32'h55AA55AA);
    step();
    check("ws0_idle_hready", 32'(rdy(1'b0)), 32'd1);

    access(1'b0, 1'b1, BASE + 32'h14, 32'h11111111, 4'hF, rd, lows, resp);
    check("ws0_wr_lows", 32'(lows), 32'd0);
    drive(1'b0, 2'b11, 1'b1, BASE + 32'h14, 4'h8);
    step();
    set_wdata(1'b0, 32'hAB000000);
    drive(1'b0, 2'b10, 1'b0, BASE + 32'h14, 4'h0);
    step();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 4'h0);
    check("ws0_fwd_merge", rdat(1'b0), 32'hAB111111);
    step();
    access(1'b0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, rd, lows, resp);
    check("ws0_rd10_mem", rd, 32'h55AA55AA);
    check("ws0_rd10_resp", 32'(resp), 32'd0);
    step();

`ifdef MSRV32_DMEM_STATS_EN
    rst_n = 1'b0;
    #1;
    check("stats_rst_rd", rd_cnt1, 32'd0);
    step();
    rst_n = 1'b1;
    access(1'b1, 1'b1, BASE + 32'h30, 32'h1, 4'hF, rd, lows, resp);
    access(1'b1, 1'b1, BASE + 32'h34, 32'h2, 4'hF, rd, lows, resp);
    access(1'b1, 1'b0, BASE + 32'h30, 32'h0, 4'h0, rd, lows, resp);
    access(1'b1, 1'b0, BASE + 32'h34, 32'h0, 4'h0, rd, lows, resp);
    access(1'b1, 1'b0, BASE + 32'h30, 32'h0, 4'h0, rd, lows, resp);
    access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, rd, lows, resp);
    step();
    check("stats_rd", rd_cnt1, 32'd3);
    check("stats_wr", wr_cnt1, 32'd2);
    check("stats_err", 32'(err_cnt1), 32'd1);
    for (int i = 0; i < 300; i++) begin
      access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, rd, lows, resp);
    end
    step();
    check("stats_err_sat", 32'(err_cnt1), 32'd255);
    check("stats_rd_after_err", rd_cnt1, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
